// File: rtl/face_session_ctrl.sv
// face_session_ctrl: session sequencer between the UART and detect_face.
// Receives one raster-ordered grayscale image, writes it into the image
// buffer, starts detection, then returns the two 32-bit face coordinates
// as 8 MSB-first bytes. It also drives RTS toward the laptop and honours
// CTS from the laptop.
module face_session_ctrl #(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int GAP_TIMEOUT = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_data_rdy,
  input  logic [7:0]  uart_data,
  input  logic        laptop_can_receive,
  output logic        fpga_can_receive,
  output logic        pix_we,
  output logic [15:0] pix_row,
  output logic [15:0] pix_col,
  output logic [7:0]  pix_data,
  output logic        img_rdy,
  input  logic        face_coords_ready,
  input  logic [63:0] face_coords,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DETECT,
    S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [63:0] coords_q, coords_d;
  logic        pix_we_q, pix_we_d;
  logic [15:0] pix_row_q, pix_row_d;
  logic [15:0] pix_col_q, pix_col_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic        last_wr_q, last_wr_d;
  logic        img_rdy_q, img_rdy_d;
  logic        fcr_q, fcr_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_overrun_q, err_overrun_d;

  logic        accept;
  logic        last_pix;
  logic        tx_fire;
  logic [63:0] send_vec;
  logic [63:0] send_shift;

  assign last_pix = (row_q == 16'(IMG_HEIGHT - 1)) && (col_q == 16'(IMG_WIDTH - 1));
  assign tx_fire  = (state_q == S_SEND) && tx_ready && laptop_can_receive;

  // Transmit byte select: coord[0] first, each coordinate MSB first.
  always_comb begin
    send_vec   = {coords_q[31:0], coords_q[63:32]};
    send_shift = send_vec << {byte_cnt_q, 3'b000};
    tx_valid   = (state_q == S_SEND);
    tx_data    = tx_valid ? send_shift[63:56] : '0;
  end

  // Next-state, index, counter and strobe computation.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    gap_d         = gap_q;
    byte_cnt_d    = byte_cnt_q;
    coords_d      = coords_q;
    pix_we_d      = 1'b0;
    pix_row_d     = pix_row_q;
    pix_col_d     = pix_col_q;
    pix_data_d    = pix_data_q;
    last_wr_d     = 1'b0;
    img_rdy_d     = last_wr_q;
    err_timeout_d = 1'b0;
    err_overrun_d = err_overrun_q;
    accept        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (uart_data_rdy) accept = 1'b1;
      end
      S_RECV: begin
        // A byte arriving in the timeout cycle takes priority.
        if (uart_data_rdy) begin
          accept = 1'b1;
        end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          row_d         = '0;
          col_d         = '0;
          gap_d         = '0;
          state_d       = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DETECT: begin
        if (uart_data_rdy) err_overrun_d = 1'b1;
        if (face_coords_ready) begin
          coords_d   = face_coords;
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (uart_data_rdy) err_overrun_d = 1'b1;
        if (tx_fire) begin
          if (byte_cnt_q == 3'd7) begin
            byte_cnt_d = '0;
            row_d      = '0;
            col_d      = '0;
            state_d    = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      pix_we_d   = 1'b1;
      pix_row_d  = row_q;
      pix_col_d  = col_q;
      pix_data_d = uart_data;
      gap_d      = '0;
      if (last_pix) begin
        row_d     = '0;
        col_d     = '0;
        last_wr_d = 1'b1;
        state_d   = S_DETECT;
      end else begin
        state_d = S_RECV;
        if (col_q == 16'(IMG_WIDTH - 1)) begin
          col_d = '0;
          row_d = row_q + 16'd1;
        end else begin
          col_d = col_q + 16'd1;
        end
      end
    end

    // RTS follows the next state so it drops together with the last pix_we.
    fcr_d = (state_d == S_IDLE) || (state_d == S_RECV);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      gap_q         <= '0;
      byte_cnt_q    <= '0;
      coords_q      <= '0;
      pix_we_q      <= 1'b0;
      pix_row_q     <= '0;
      pix_col_q     <= '0;
      pix_data_q    <= '0;
      last_wr_q     <= 1'b0;
      img_rdy_q     <= 1'b0;
      fcr_q         <= 1'b1;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      gap_q         <= gap_d;
      byte_cnt_q    <= byte_cnt_d;
      coords_q      <= coords_d;
      pix_we_q      <= pix_we_d;
      pix_row_q     <= pix_row_d;
      pix_col_q     <= pix_col_d;
      pix_data_q    <= pix_data_d;
      last_wr_q     <= last_wr_d;
      img_rdy_q     <= img_rdy_d;
      fcr_q         <= fcr_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign fpga_can_receive = fcr_q;
  assign pix_we           = pix_we_q;
  assign pix_row          = pix_row_q;
  assign pix_col          = pix_col_q;
  assign pix_data         = pix_data_q;
  assign img_rdy          = img_rdy_q;
  assign busy             = (state_q != S_IDLE);
  assign err_timeout      = err_timeout_q;
  assign err_overrun      = err_overrun_q;

endmodule

// File: tb/tb_face_session_ctrl.sv
// Testbench for face_session_ctrl with a 4x3 image and a short gap timeout.
module tb_face_session_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int GAP  = 16;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_data_rdy = 1'b0;
  logic [7:0]  uart_data = '0;
  logic        cts = 1'b0;
  logic        fpga_can_receive;
  logic        pix_we;
  logic [15:0] pix_row;
  logic [15:0] pix_col;
  logic [7:0]  pix_data;
  logic        img_rdy;
  logic        face_coords_ready = 1'b0;
  logic [63:0] face_coords = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        err_timeout;
  logic        err_overrun;

  int checks = 0;
  int errors = 0;

  logic [39:0] pix_q[$];
  logic [7:0]  tx_q[$];

  face_session_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .GAP_TIMEOUT(GAP)
  ) dut (
    .clock             (clk),
    .reset             (rst_n),
    .uart_data_rdy     (uart_data_rdy),
    .uart_data         (uart_data),
    .laptop_can_receive(cts),
    .fpga_can_receive  (fpga_can_receive),
    .pix_we            (pix_we),
    .pix_row           (pix_row),
    .pix_col           (pix_col),
    .pix_data          (pix_data),
    .img_rdy           (img_rdy),
    .face_coords_ready (face_coords_ready),
    .face_coords       (face_coords),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .err_timeout       (err_timeout),
    .err_overrun       (err_overrun)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({fpga_can_receive, busy, pix_we, img_rdy, tx_valid, err_timeout, err_overrun} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_state: got %b want 1000000",
               {fpga_can_receive, busy, pix_we, img_rdy, tx_valid, err_timeout, err_overrun});
    end
    // face_coords_ready while idle must be ignored
    face_coords = 64'h1111_2222_3333_4444;
    @(posedge clk); #1 face_coords_ready = 1'b1;
    @(posedge clk); #1 face_coords_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore_coords: busy=%b tx_valid=%b want 0 0", busy, tx_valid);
    end
  endtask

  // Sends n raster bytes (base+k) starting at pixel 0; full image when n==NPIX.
  task automatic test_bytes(input logic [7:0] base, input int n);
    logic [39:0] exp;
    for (int k = 0; k < n; k++) begin
      pix_q.push_back({16'(k / W), 16'(k % W), 8'(base + 8'(k))});
      @(posedge clk); #1 uart_data_rdy = 1'b1; uart_data = 8'(base + 8'(k));
      @(posedge clk); #1 uart_data_rdy = 1'b0;
      @(negedge clk);
      exp = pix_q.pop_front();
      checks++;
      if (pix_we !== 1'b1) begin
        errors++;
        $display("FAIL pix_we k=%0d: got %b want 1", k, pix_we);
      end else begin
        checks++;
        if ({pix_row, pix_col, pix_data} !== exp) begin
          errors++;
          $display("FAIL pix_write k=%0d: got r%0d c%0d d%0h want r%0d c%0d d%0h",
                   k, pix_row, pix_col, pix_data, exp[39:24], exp[23:8], exp[7:0]);
        end
      end
      checks++;
      if (fpga_can_receive !== 1'(k != NPIX - 1)) begin
        errors++;
        $display("FAIL rts k=%0d: got %b want %b", k, fpga_can_receive, k != NPIX - 1);
      end
      checks++;
      if (img_rdy !== 1'b0) begin
        errors++;
        $display("FAIL img_rdy_early k=%0d: got %b want 0", k, img_rdy);
      end
    end
    if (n == NPIX) begin
      @(negedge clk);
      checks++;
      if (img_rdy !== 1'b1 || busy !== 1'b1 || pix_we !== 1'b0) begin
        errors++;
        $display("FAIL img_rdy_pulse: img_rdy=%b busy=%b pix_we=%b want 1 1 0", img_rdy, busy, pix_we);
      end
      @(negedge clk);
      checks++;
      if (img_rdy !== 1'b0 || fpga_can_receive !== 1'b0) begin
        errors++;
        $display("FAIL img_rdy_single: img_rdy=%b rts=%b want 0 0", img_rdy, fpga_can_receive);
      end
    end
  endtask

  // Delivers coordinates and drains the 8 reply bytes, optionally stalling CTS.
  task automatic test_send(input logic [31:0] c1, input logic [31:0] c0,
                           input int stall_after, input int stall_len);
    int xfers = 0;
    int cycles = 0;
    int stall = 0;
    bit stalled = 0;
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(c0 >> (24 - 8 * i)));
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(c1 >> (24 - 8 * i)));
    tx_ready = 1'b1;
    cts = 1'b1;
    face_coords = {c1, c0};
    @(posedge clk); #1 face_coords_ready = 1'b1;
    @(posedge clk); #1 face_coords_ready = 1'b0;
    while (tx_q.size() > 0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
        errors++;
        $display("FAIL tx_byte %0d: valid=%b data=%h want 1 %h", xfers, tx_valid, tx_data, tx_q[0]);
      end
      if (tx_valid && tx_ready && cts) begin
        void'(tx_q.pop_front());
        xfers++;
      end else if (stall > 0) begin
        stall--;
      end
      @(posedge clk); #1;
      if (stall_len > 0 && !stalled && xfers == stall_after) begin
        cts = 1'b0;
        stall = stall_len;
        stalled = 1;
      end else if (stalled && stall == 0) begin
        cts = 1'b1;
      end
    end
    checks++;
    if (xfers !== 8 || cycles !== 8 + stall_len) begin
      errors++;
      $display("FAIL tx_count: xfers=%0d cycles=%0d want 8 %0d", xfers, cycles, 8 + stall_len);
    end
    tx_q.delete();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || fpga_can_receive !== 1'b1) begin
      errors++;
      $display("FAIL send_done: valid=%b busy=%b rts=%b want 0 0 1", tx_valid, busy, fpga_can_receive);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    test_bytes(8'h80, 5);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || busy !== 1'b0 || fpga_can_receive !== 1'b1) begin
      errors++;
      $display("FAIL timeout: pulses=%0d busy=%b rts=%b want 1 0 1", pulses, busy, fpga_can_receive);
    end
    test_bytes(8'h40, NPIX);
    test_send(32'hDEAD_BEEF, 32'h0102_0304, 0, 0);
  endtask

  task automatic test_overrun();
    test_bytes(8'h10, NPIX);
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b want 0", err_overrun);
    end
    @(posedge clk); #1 uart_data_rdy = 1'b1; uart_data = 8'h55;
    @(posedge clk); #1 uart_data_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_we !== 1'b0 || err_overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: pix_we=%b err=%b busy=%b want 0 1 1", pix_we, err_overrun, busy);
    end
    test_send(32'hA5A5_0F0F, 32'h7766_5544, 0, 0);
    test_bytes(8'h30, NPIX);
    test_send(32'h0000_0001, 32'h8000_0000, 0, 0);
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b want 1", err_overrun);
    end
  endtask

  task automatic test_midreset();
    test_bytes(8'h00, 7);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fpga_can_receive !== 1'b1 || pix_we !== 1'b0 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset: busy=%b rts=%b pix_we=%b err=%b want 0 1 0 0",
               busy, fpga_can_receive, pix_we, err_overrun);
    end
    test_bytes(8'h90, NPIX);
    test_send(32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_bytes(8'h00, NPIX);
    test_send(32'h0000_0040, 32'h0000_0020, 0, 0);
    test_bytes(8'h20, NPIX);
    test_send(32'h0000_0040, 32'h0000_0020, 3, 10);
    test_timeout();
    test_overrun();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/face_session_ctrl.md
Name: face_session_ctrl

Overview:
Top-level session sequencer between the UART byte receiver/transmitter and detect_face. It receives one raster-ordered grayscale image from the laptop, writes each pixel into the image buffer, and starts detection. It then returns the two 32-bit face coordinates as 8 bytes and drives the RTS/CTS flow control throughout.

Parameters:
IMG_WIDTH, 320, pixels per row (columns)
IMG_HEIGHT, 240, rows per image
GAP_TIMEOUT, 1000000, max clock cycles allowed between received bytes while in RECV

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
uart_data_rdy  input  1  one-cycle pulse: uart_data valid
uart_data  input  8  received byte (pixel)
laptop_can_receive  input  1  CTS from laptop; high = laptop accepts bytes
fpga_can_receive  output  1  RTS to laptop; high = FPGA accepts bytes
pix_we  output  1  one-cycle pixel write strobe to image buffer
pix_row  output  16  row index of pixel being written
pix_col  output  16  column index of pixel being written
pix_data  output  8  pixel value being written
img_rdy  output  1  one-cycle pulse: image complete, start detect_face
face_coords_ready  input  1  detect_face result strobe
face_coords  input  64  {coord[1], coord[0]}, 32 bits each
tx_valid  output  1  byte available for UART transmitter
tx_data  output  8  byte to transmit
tx_ready  input  1  UART transmitter can accept a byte
busy  output  1  high in any state other than IDLE
err_timeout  output  1  one-cycle pulse: receive aborted on byte gap
err_overrun  output  1  sticky: a byte arrived outside IDLE/RECV; cleared only by reset

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, fpga_can_receive=1. All other outputs 0. Indices, gap counter, byte counter and coordinate latch cleared. Reset mid-operation abandons the session with no partial output.
- States: IDLE, RECV, DETECT, SEND.
- IDLE: fpga_can_receive=1. On uart_data_rdy, write pixel (0,0) and go to RECV (or straight to DETECT if IMG_WIDTH*IMG_HEIGHT==1).
- Pixel write, any accepted byte: in the cycle after uart_data_rdy, pix_we=1 for exactly one cycle with pix_row/pix_col/pix_data = the current index and the byte.
- Index update: pix_col increments; when pix_col==IMG_WIDTH-1 it wraps to 0 and pix_row increments. Strict raster order; pixel k maps to (k/IMG_WIDTH, k%IMG_WIDTH).
- RECV: each uart_data_rdy writes the next pixel and clears the gap counter. Otherwise the gap counter increments.
- Last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) written:
  - fpga_can_receive drops to 0 in the same cycle as that pix_we.
  - img_rdy pulses in the following cycle.
  - State goes to DETECT.
- Gap timeout in RECV: gap counter reaches GAP_TIMEOUT with no byte:
  - err_timeout pulses for one cycle.
  - Indices reset to 0; state returns to IDLE with fpga_can_receive=1.
  - If a byte and the timeout coincide in the same cycle, the byte wins.
- DETECT: wait for face_coords_ready, then latch face_coords and go to SEND. face_coords_ready in any other state is ignored.
- Overrun: uart_data_rdy in DETECT or SEND sets err_overrun and the byte is discarded (no pix_we).
- SEND: 8 bytes in order:
  - coord[0][31:24], [23:16], [15:8], [7:0], then coord[1] in the same MSB-first order.
  - tx_valid is held high with tx_data stable until a transfer cycle: tx_valid && tx_ready && laptop_can_receive.
  - A byte may transfer every cycle; after a transfer, tx_data advances next cycle.
  - CTS low stalls with tx_valid held.
  - After the 8th transfer: tx_valid=0, state IDLE, fpga_can_receive=1 in the next cycle, indices 0.
- busy = (state != IDLE).
- Widths: gap counter sized ceil(log2(GAP_TIMEOUT+1)); byte counter 3 bits; no arithmetic overflow is permitted.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=3, send bytes 0..11 -> pix_we 12 times with (row,col) = (0,0),(0,1)..(2,3) and pix_data=k. fpga_can_receive falls with the 12th pix_we, img_rdy pulses once one cycle later.
2. After (1), face_coords={32'h0000_0040, 32'h0000_0020}, tx_ready=1, CTS=1 -> tx_data sequence 00,00,00,20,00,00,00,40 on consecutive cycles, then IDLE with fpga_can_receive=1.
3. In SEND, deassert CTS after the 3rd byte for 10 cycles -> tx_valid held with tx_data=20 and no transfer. It resumes when CTS returns, and all 8 bytes are delivered exactly once.
4. GAP_TIMEOUT=16, send 5 bytes then idle -> err_timeout pulses once, state IDLE. A new 12-byte image then writes starting from (0,0).
5. Inject uart_data_rdy during DETECT -> no pix_we, err_overrun=1 and stays 1 through the next session until reset.
6. Assert reset low for 1 cycle after 7 received bytes -> next cycle busy=0, fpga_can_receive=1, and a new image writes starting from (0,0).
